instr_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instruction words into the 256-word instruction memory. It is the write-side counterpart of the memory's asynchronous fetch port. It takes a framed byte stream from the host link (UART receiver or testbench) over a valid/ready handshake and assembles big-endian words. Each word is written to memory with a one-cycle write strobe, and the CPU is held in reset while loading is in progress.

---
 rtl/instr_loader_pkg.sv | 18 +
 rtl/instr_loader.sv | 99 +++++++++
 tb/tb_instr_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package instr_loader_pkg;

   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 16;
   localparam int BYTES_PER_WORD = 2;
   localparam int REM_W          = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      HI,
      LO,
      WRITE,
      CHECK
   } state_t;

endpackage

// File: rtl/instr_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory as
// big-endian 16-bit words, holding the CPU while the load is in progress.
//
// state | meaning
// IDLE  | waiting for start; CPU released
// COUNT | accept word count N (0 means 256)
// HI    | accept high byte of the current word
// LO    | accept low byte of the current word
// WRITE | one-cycle memory write strobe, advance address
// CHECK | accept checksum byte, flag done or error
module instr_loader
   import instr_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t           state;
   logic [REM_W-1:0] remaining;
   logic [7:0]       acc;
   logic             xfer;

   assign rx_ready = (state == COUNT) || (state == HI) || (state == LO) || (state == CHECK);
   assign mem_we   = (state == WRITE);
   assign busy     = (state != IDLE);
   assign cpu_hold = (state != IDLE);
   assign xfer     = rx_valid && rx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         remaining <= '0;
         acc       <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  error    <= 1'b0;
                  mem_addr <= base_addr;
                  acc      <= '0;
                  state    <= COUNT;
               end
            end
            COUNT: begin
               if (xfer) begin
                  // a zero count byte encodes the full 256-word memory
                  remaining <= (rx_data == 8'h00) ? REM_W'(256) : REM_W'(rx_data);
                  state     <= HI;
               end
            end
            HI: begin
               if (xfer) begin
                  mem_wdata[15:8] <= rx_data;
                  acc             <= acc ^ rx_data;
                  state           <= LO;
               end
            end
            LO: begin
               if (xfer) begin
                  mem_wdata[7:0] <= rx_data;
                  acc            <= acc ^ rx_data;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               mem_addr  <= mem_addr + ADDR_W'(1);
               remaining <= remaining - REM_W'(1);
               state     <= (remaining == REM_W'(1)) ? CHECK : HI;
            end
            CHECK: begin
               if (xfer) begin
                  if (rx_data == acc) done  <= 1'b1;
                  else                error <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: table of frames plus hand-written corner sequences.
module tb_instr_loader;
   import instr_loader_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              error;

   always #5 clk = ~clk;

   instr_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   typedef struct {
      logic [7:0]  base;
      logic [7:0]  count;
      logic [15:0] w0;
      logic [15:0] w1;
      bit          gen;
      bit          bad_cs;
      bit          gaps;
      int          exp_done;
      int          exp_err;
      int          exp_busy;
   } vec_t;

   vec_t        vecs [6];
   logic [15:0] words [256];

   int total = 0;
   int bad   = 0;

   // write log and protocol monitor, sampled mid-cycle
   logic [7:0]  wr_addr [2048];
   logic [15:0] wr_data [2048];
   int          wr_n = 0, done_n = 0, busy_n = 0, viol_n = 0;
   logic        we_prev = 1'b0;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr[wr_n % 2048] = mem_addr;
         wr_data[wr_n % 2048] = mem_wdata;
         wr_n++;
      end
      if (mem_we && rx_ready) viol_n++;
      if (mem_we && we_prev)  viol_n++;
      if (mem_we && !busy)    viol_n++;
      if (busy !== cpu_hold)  viol_n++;
      if (done)   done_n++;
      if (busy)   busy_n++;
      we_prev = mem_we;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit taken = 1'b0;
      if (gaps) begin
         rx_valid = 1'b0;
         repeat ($urandom_range(4, 0)) @(negedge clk);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 20 && !taken; k++) begin
         taken = rx_ready;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      if (!taken) begin
         total++;
         bad++;
         $display("FAIL rx_timeout: byte %0h not accepted within 20 cycles", b);
      end
   endtask

   task automatic pulse_start(input logic [7:0] b);
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t       v;
      int         n, w0, d0, b0, v0, errs;
      logic [7:0] cs;
      v  = vecs[idx];
      n  = (v.count == 8'h00) ? 256 : int'(v.count);
      cs = 8'h00;
      for (int j = 0; j < n; j++) begin
         if (v.gen) words[j] = {8'(j * 3 + 1), 8'(j) ^ 8'h3C};
         else       words[j] = (j == 0) ? v.w0 : v.w1;
         cs = cs ^ words[j][15:8] ^ words[j][7:0];
      end
      if (v.bad_cs) cs = cs ^ 8'h01;
      w0 = wr_n; d0 = done_n; b0 = busy_n; v0 = viol_n;
      pulse_start(v.base);
      check($sformatf("v%0d_err_cleared_by_start", idx), error, 0);
      send_byte(v.count, v.gaps);
      for (int j = 0; j < n; j++) begin
         send_byte(words[j][15:8], v.gaps);
         send_byte(words[j][7:0], v.gaps);
      end
      send_byte(cs, v.gaps);
      check($sformatf("v%0d_busy_after_cs", idx), {busy, cpu_hold}, 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_write_count", idx), wr_n - w0, n);
      errs = 0;
      for (int j = 0; j < n; j++) begin
         if (wr_addr[(w0 + j) % 2048] !== 8'(v.base + 8'(j)) ||
             wr_data[(w0 + j) % 2048] !== words[j]) errs++;
      end
      check($sformatf("v%0d_write_contents_bad", idx), errs, 0);
      check($sformatf("v%0d_done_pulses", idx), done_n - d0, v.exp_done);
      check($sformatf("v%0d_error", idx), error, v.exp_err);
      if (v.exp_busy != 0)
         check($sformatf("v%0d_busy_cycles", idx), busy_n - b0, v.exp_busy);
      check($sformatf("v%0d_protocol_violations", idx), viol_n - v0, 0);
   endtask

   initial begin
      int w0, d0;
      //          base   count  w0       w1       gen   bad   gaps  done err busy
      vecs[0] = '{8'h00, 8'h02, 16'h2108, 16'h2209, 1'b0, 1'b0, 1'b0, 1, 0, 8};
      vecs[1] = '{8'h00, 8'h02, 16'h2108, 16'h2209, 1'b0, 1'b1, 1'b0, 0, 1, 8};
      vecs[2] = '{8'hFE, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0, 770};
      vecs[3] = '{8'h10, 8'h02, 16'h2108, 16'h2209, 1'b0, 1'b0, 1'b1, 1, 0, 0};
      vecs[4] = '{8'h80, 8'h05, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 0, 1, 0};
      vecs[5] = '{8'hFF, 8'h01, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0, 5};

      #12;
      check("reset_outputs",
            {rx_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_vec(0);
      run_vec(1);
      repeat (4) @(negedge clk);
      check("error_sticky_while_idle", error, 1);
      for (int i = 2; i < 6; i++) run_vec(i);

      // start during HI is ignored and the new base_addr has no effect
      w0 = wr_n; d0 = done_n;
      pulse_start(8'h20);
      send_byte(8'h02, 1'b0);
      start     = 1'b1;
      base_addr = 8'h77;
      @(negedge clk);
      start     = 1'b0;
      check("midload_start_busy", busy, 1);
      check("midload_start_addr", mem_addr, 8'h20);
      send_byte(8'h21, 1'b0); send_byte(8'h08, 1'b0);
      send_byte(8'h22, 1'b0); send_byte(8'h09, 1'b0);
      send_byte(8'h02, 1'b0);
      repeat (3) @(negedge clk);
      check("midload_start_writes", wr_n - w0, 2);
      check("midload_start_w0", {wr_addr[w0 % 2048], wr_data[w0 % 2048]}, 24'h20_2108);
      check("midload_start_w1", {wr_addr[(w0 + 1) % 2048], wr_data[(w0 + 1) % 2048]}, 24'h21_2209);
      check("midload_start_done", done_n - d0, 1);

      // asynchronous reset after the first word's write
      w0 = wr_n;
      pulse_start(8'h40);
      send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      check("pre_reset_addr", mem_addr, 8'h41);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {rx_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata}, 0);
      check("writes_before_reset", wr_n - w0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
